wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 90 +++++++++
 rtl/wb_queue.sv | 88 ++++++++
 tb/tb_wb_queue.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and entry type for the register-file write-back queue.
package wb_pkg;

    localparam int M_DEFAULT     = 32;
    localparam int A_DEFAULT     = 4;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [A_DEFAULT-1:0] addr;
        logic [M_DEFAULT-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending write-backs, with per-slot valid bits so the
// parent can run an associative hazard lookup over everything still queued.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int M     = M_DEFAULT,
    parameter int A     = A_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_i,
    input  logic [A-1:0]              pushAddr_i,
    input  logic [M-1:0]              pushData_i,
    input  logic                      pop_i,
    output logic [A-1:0]              headAddr_o,
    output logic [M-1:0]              headData_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DEPTH-1:0]          entryValid_o,
    output logic [DEPTH-1:0][A-1:0]   entryAddr_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [A-1:0]     addrMem_q [DEPTH];
    logic [M-1:0]     dataMem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        valid_d = valid_q;
        if (push_i) begin
            wrPtr_d          = wrPtr_q + PW'(1);
            valid_d[wrPtr_q] = 1'b1;
        end
        if (pop_i) begin
            rdPtr_d          = rdPtr_q + PW'(1);
            valid_d[rdPtr_q] = 1'b0;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload is left alone on reset; the valid bits alone decide liveness.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addrMem_q[wrPtr_q] <= pushAddr_i;
            dataMem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_comb begin
        headAddr_o   = addrMem_q[rdPtr_q];
        headData_o   = dataMem_q[rdPtr_q];
        full_o       = (count_q == CW'(DEPTH));
        empty_o      = (count_q == '0);
        count_o      = count_q;
        entryValid_o = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            entryAddr_o[i] = addrMem_q[i];
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue in front of the register file: arbitrates ALU and load
// results, drops writes to r0, and answers source-register hazard queries.
module wb_queue
    import wb_pkg::*;
#(
    parameter int M     = M_DEFAULT,
    parameter int A     = A_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [A-1:0]           alu_addr,
    input  logic [M-1:0]           alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [A-1:0]           mem_addr,
    input  logic [M-1:0]           mem_data,
    output logic                   mem_ready,
    input  logic                   rf_stall,
    output logic                   rf_we,
    output logic [A-1:0]           rf_addr,
    output logic [M-1:0]           rf_data,
    input  logic [A-1:0]           hz_addr,
    output logic                   hz_pending,
    output logic [$clog2(DEPTH):0] count
);

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    reqAccept;
    logic [A-1:0]            reqAddr;
    logic [M-1:0]            reqData;
    logic [A-1:0]            headAddr;
    logic [M-1:0]            headData;
    logic [DEPTH-1:0]        entryValid;
    logic [DEPTH-1:0][A-1:0] entryAddr;

    wb_fifo #(
        .M     (M),
        .A     (A),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .pushAddr_i   (reqAddr),
        .pushData_i   (reqData),
        .pop_i        (pop),
        .headAddr_o   (headAddr),
        .headData_o   (headData),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .entryValid_o (entryValid),
        .entryAddr_o  (entryAddr)
    );

    // Loads take priority; readiness depends only on full, never on a pop.
    always_comb begin
        mem_ready = !full && !reset;
        alu_ready = !full && !mem_valid && !reset;
        reqAccept = (mem_valid && mem_ready) || (alu_valid && alu_ready);
        reqAddr   = mem_valid ? mem_addr : alu_addr;
        reqData   = mem_valid ? mem_data : alu_data;
        push      = reqAccept && (reqAddr != '0);
        pop       = !empty && !rf_stall && !reset;
        rf_we     = pop;
        rf_addr   = pop ? headAddr : '0;
        rf_data   = pop ? headData : '0;
    end

    // Only stored entries are searched, so a same-cycle request is invisible.
    always_comb begin
        hz_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entryAddr[i] == hz_addr)) begin
                hz_pending = 1'b1;
            end
        end
        if ((hz_addr == '0) || reset) begin
            hz_pending = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed scoreboard bench for wb_queue: expected register-file writes are
// queued as requests are accepted and checked by an independent port monitor.
module tb_wb_queue;

    localparam int M     = 32;
    localparam int A     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [A-1:0] addr;
        logic [M-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [A-1:0]  alu_addr;
    logic [M-1:0]  alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [A-1:0]  mem_addr;
    logic [M-1:0]  mem_data;
    logic          mem_ready;
    logic          rf_stall;
    logic          rf_we;
    logic [A-1:0]  rf_addr;
    logic [M-1:0]  rf_data;
    logic [A-1:0]  hz_addr;
    logic          hz_pending;
    logic [CW-1:0] count;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wb_queue #(
        .M     (M),
        .A     (A),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .rf_stall   (rf_stall),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .hz_addr    (hz_addr),
        .hz_pending (hz_pending),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input logic [A-1:0] addr, input logic [M-1:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    // One-cycle request that must be accepted; r0 writes never reach the scoreboard.
    task automatic applyStimulus(input bit isMem, input logic [A-1:0] addr,
                                 input logic [M-1:0] data, input bit expectWrite);
        if (isMem) begin
            mem_valid = 1'b1;
            mem_addr  = addr;
            mem_data  = data;
        end else begin
            alu_valid = 1'b1;
            alu_addr  = addr;
            alu_data  = data;
        end
        @(negedge clk);
        if (isMem) checkOutput("memReadyAccept", mem_ready, 1);
        else       checkOutput("aluReadyAccept", alu_ready, 1);
        @(posedge clk);
        if (expectWrite && addr != '0) pushExpected(addr, data);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && count == '0) break;
            tick();
        end
        @(negedge clk);
        checkOutput("drainScoreboard", sb.size(), 0);
        checkOutput("drainCount", count, 0);
        tick();
    endtask

    // Port monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rf_we) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedWrite: got addr %0h data %0h expected no write", rf_addr, rf_data);
            end else begin
                e = sb.pop_front();
                checkOutput("rfAddr", rf_addr, e.addr);
                checkOutput("rfData", rf_data, e.data);
            end
        end else begin
            checkOutput("idlePortZero", {rf_addr, rf_data}, 0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int accepted;
        int cycles;
        bit take;

        reset     = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        rf_stall  = 1'b0;
        hz_addr   = 4'd5;

        @(negedge clk);
        checkOutput("resetRfWe", rf_we, 0);
        checkOutput("resetMemReady", mem_ready, 0);
        checkOutput("resetAluReady", alu_ready, 0);
        checkOutput("resetHz", hz_pending, 0);
        checkOutput("resetCount", count, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idleMemReady", mem_ready, 1);
        checkOutput("idleAluReady", alu_ready, 1);
        checkOutput("idleCount", count, 0);
        tick();

        $display("[TB] single ALU write");
        applyStimulus(0, 4'd5, 32'hDEADBEEF, 1);
        @(negedge clk);
        checkOutput("singleCount1", count, 1);
        checkOutput("singleRfWe", rf_we, 1);
        tick();
        @(negedge clk);
        checkOutput("singleCount0", count, 0);
        tick();

        $display("[TB] load beats ALU");
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h33333333;
        mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 32'h77777777;
        @(negedge clk);
        checkOutput("arbMemReady", mem_ready, 1);
        checkOutput("arbAluReady", alu_ready, 0);
        @(posedge clk);
        pushExpected(4'd7, 32'h77777777);
        #1;
        mem_valid = 1'b0;
        @(negedge clk);
        checkOutput("retryAluReady", alu_ready, 1);
        @(posedge clk);
        pushExpected(4'd3, 32'h33333333);
        #1;
        alu_valid = 1'b0;
        waitDrain();

        $display("[TB] fill under stall");
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(i[0], A'(i), 32'h1000 + i, 1);
        end
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 32'h55;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("fullCount", count, 4);
            checkOutput("fullMemReady", mem_ready, 0);
            checkOutput("fullAluReady", alu_ready, 0);
            tick();
        end
        mem_valid = 1'b0;
        rf_stall  = 1'b0;
        @(negedge clk);
        checkOutput("fullPopRfWe", rf_we, 1);
        checkOutput("fullPopMemReady", mem_ready, 0);
        tick();
        @(negedge clk);
        checkOutput("afterPopMemReady", mem_ready, 1);
        checkOutput("afterPopCount", count, 3);
        waitDrain();

        $display("[TB] hazard query and r0 filter");
        rf_stall = 1'b1;
        applyStimulus(1, 4'd9, 32'h99, 1);
        hz_addr = 4'd9;
        @(negedge clk);
        checkOutput("hzHit9", hz_pending, 1);
        tick();
        hz_addr = 4'd4;
        @(negedge clk);
        checkOutput("hzMiss4", hz_pending, 0);
        tick();
        hz_addr = 4'd0;
        applyStimulus(0, 4'd0, 32'hABCD, 1);
        @(negedge clk);
        checkOutput("hzR0", hz_pending, 0);
        checkOutput("r0NotQueued", count, 1);
        tick();
        hz_addr   = 4'd6;
        alu_valid = 1'b1; alu_addr = 4'd6; alu_data = 32'h66;
        @(negedge clk);
        checkOutput("hzExcludesIncoming", hz_pending, 0);
        @(posedge clk);
        pushExpected(4'd6, 32'h66);
        #1;
        alu_valid = 1'b0;
        @(negedge clk);
        checkOutput("hzQueued6", hz_pending, 1);
        tick();
        rf_stall = 1'b0;
        hz_addr  = 4'd9;
        @(negedge clk);
        checkOutput("hzHeadPopRfWe", rf_we, 1);
        checkOutput("hzHeadPopping", hz_pending, 1);
        tick();
        waitDrain();

        $display("[TB] reset mid-operation");
        rf_stall = 1'b1;
        applyStimulus(0, 4'd11, 32'hB0B0, 0);
        applyStimulus(1, 4'd12, 32'hC0C0, 0);
        applyStimulus(0, 4'd13, 32'hD0D0, 0);
        @(negedge clk);
        checkOutput("preResetCount", count, 3);
        tick();
        reset    = 1'b1;
        rf_stall = 1'b0;
        hz_addr  = 4'd11;
        @(negedge clk);
        checkOutput("inResetRfWe", rf_we, 0);
        checkOutput("inResetMemReady", mem_ready, 0);
        checkOutput("inResetAluReady", alu_ready, 0);
        checkOutput("inResetHz", hz_pending, 0);
        tick();
        reset    = 1'b0;
        rf_stall = 1'b1;
        @(negedge clk);
        checkOutput("postResetCount", count, 0);
        checkOutput("postResetRfWe", rf_we, 0);
        tick();
        rf_stall = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        checkOutput("postResetHz", hz_pending, 0);
        tick();

        $display("[TB] continuous writes across wrap");
        accepted = 0;
        cycles   = 0;
        while (accepted < 2 * DEPTH + 3 && cycles < 200) begin
            mem_valid = 1'b1;
            mem_addr  = A'((accepted % 15) + 1);
            mem_data  = 32'hA5000000 + 32'(accepted) * 32'h111;
            rf_stall  = cycles[0];
            @(negedge clk);
            take = mem_ready;
            @(posedge clk);
            if (take) begin
                pushExpected(mem_addr, mem_data);
                accepted++;
            end
            #1;
            cycles++;
        end
        mem_valid = 1'b0;
        rf_stall  = 1'b0;
        checkOutput("wrapAccepted", accepted, 2 * DEPTH + 3);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
